// File: rtl/multicycle_control_if.sv
// Bundle of instruction-side inputs and datapath control outputs exchanged
// between the multicycle main controller and the datapath.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       mem_ready;

  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       ExtOp;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  // Controller side: reads the opcode and memory handshake, drives controls.
  modport master (
    input  Op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB, ALUOp,
           PCSource, state, instr_done, illegal_op
  );

  // Datapath side: supplies the opcode and handshake, consumes controls.
  modport slave (
    output Op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB, ALUOp,
           PCSource, state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Main controller for a multicycle MIPS-style datapath. A Moore FSM walks
// each instruction through fetch, decode and its execution states; the
// opcode is captured during DECODE so later states ignore the live Op field.
// Controls are decoded from the current state and forced low during reset so
// no memory or PC write can be issued while the machine is being reset.
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    IEX    = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       decode_illegal;

  // Next-state selection, opcode capture in DECODE, and illegal-opcode detect.
  always_comb begin
    state_d        = FETCH;
    op_d           = op_q;
    decode_illegal = 1'b0;
    case (state_q)
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        op_d = bus.Op;
        case (bus.Op)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_R:                              state_d = REX;
          OP_BEQ:                            state_d = BEQ;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = IEX;
          default: begin
            state_d        = FETCH;
            decode_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
      REX:    state_d = RWB;
      RWB:    state_d = FETCH;
      BEQ:    state_d = FETCH;
      IEX:    state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls per state; everything held low while reset is asserted.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ExtOp       = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = ALU_ADD;
    bus.PCSource    = 2'b00;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        DECODE: begin
          bus.ALUSrcB    = 2'b11;
          bus.illegal_op = decode_illegal;
        end
        MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEMRD: begin
          bus.IorD    = 1'b1;
          bus.MemRead = 1'b1;
        end
        MEMWB: begin
          bus.MemtoReg   = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEMWR: begin
          bus.IorD       = 1'b1;
          bus.MemWrite   = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        REX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = ALU_FUNCT;
        end
        RWB: begin
          bus.RegDst     = 1'b1;
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        BEQ: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = ALU_SUB;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
          bus.instr_done  = 1'b1;
        end
        IEX: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ExtOp   = (op_q != OP_ADDI);
          case (op_q)
            OP_ANDI: bus.ALUOp = ALU_AND;
            OP_ORI:  bus.ALUOp = ALU_OR;
            OP_XORI: bus.ALUOp = ALU_XOR;
            default: bus.ALUOp = ALU_ADD;
          endcase
        end
        IWB: begin
          bus.RegWrite   = 1'b1;
          bus.instr_done = 1'b1;
        end
        JUMP: begin
          bus.PCWrite    = 1'b1;
          bus.PCSource   = 2'b10;
          bus.instr_done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // State and captured opcode registers; reset wins over every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control: each table row is one
// clock cycle of inputs with the hand-derived state and control word, followed
// by per-instruction latency measurements.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] OP_BAD2 = 6'b000001;

  // Control word bit masks: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
  // IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB[1:0],
  // ALUOp[2:0], PCSource[1:0], instr_done, illegal_op}
  localparam logic [19:0] PCW     = 20'h80000;
  localparam logic [19:0] PCWC    = 20'h40000;
  localparam logic [19:0] IORD    = 20'h20000;
  localparam logic [19:0] MRD     = 20'h10000;
  localparam logic [19:0] MWR     = 20'h08000;
  localparam logic [19:0] IRW     = 20'h04000;
  localparam logic [19:0] M2R     = 20'h02000;
  localparam logic [19:0] RDST    = 20'h01000;
  localparam logic [19:0] RWR     = 20'h00800;
  localparam logic [19:0] SRCA    = 20'h00400;
  localparam logic [19:0] EXT     = 20'h00200;
  localparam logic [19:0] SB_4    = 20'h00080;
  localparam logic [19:0] SB_IMM  = 20'h00100;
  localparam logic [19:0] SB_IMM2 = 20'h00180;
  localparam logic [19:0] A_SUB   = 20'h00010;
  localparam logic [19:0] A_FUNCT = 20'h00020;
  localparam logic [19:0] A_AND   = 20'h00030;
  localparam logic [19:0] A_OR    = 20'h00040;
  localparam logic [19:0] A_XOR   = 20'h00050;
  localparam logic [19:0] PCS_OUT = 20'h00004;
  localparam logic [19:0] PCS_J   = 20'h00008;
  localparam logic [19:0] DONE    = 20'h00002;
  localparam logic [19:0] ILL     = 20'h00001;

  localparam logic [19:0] C_RST    = 20'h00000;
  localparam logic [19:0] C_FRDY   = MRD | SB_4 | IRW | PCW;
  localparam logic [19:0] C_FWAIT  = MRD | SB_4;
  localparam logic [19:0] C_DEC    = SB_IMM2;
  localparam logic [19:0] C_DECILL = SB_IMM2 | ILL;
  localparam logic [19:0] C_MADR   = SRCA | SB_IMM;
  localparam logic [19:0] C_MRD    = IORD | MRD;
  localparam logic [19:0] C_MWB    = M2R | RWR | DONE;
  localparam logic [19:0] C_MWRW   = IORD | MWR;
  localparam logic [19:0] C_MWRD   = IORD | MWR | DONE;
  localparam logic [19:0] C_REX    = SRCA | A_FUNCT;
  localparam logic [19:0] C_RWB    = RDST | RWR | DONE;
  localparam logic [19:0] C_BEQ    = SRCA | A_SUB | PCWC | PCS_OUT | DONE;
  localparam logic [19:0] C_ADDI   = SRCA | SB_IMM;
  localparam logic [19:0] C_ANDI   = SRCA | SB_IMM | A_AND | EXT;
  localparam logic [19:0] C_ORI    = SRCA | SB_IMM | A_OR | EXT;
  localparam logic [19:0] C_XORI   = SRCA | SB_IMM | A_XOR | EXT;
  localparam logic [19:0] C_IWB    = RWR | DONE;
  localparam logic [19:0] C_JMP    = PCW | PCS_J | DONE;

  typedef struct {
    string       label;
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  multicycle_control_if bus();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [19:0] act_ctl;
  assign act_ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                    bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                    bus.RegWrite, bus.ALUSrcA, bus.ExtOp, bus.ALUSrcB,
                    bus.ALUOp, bus.PCSource, bus.instr_done, bus.illegal_op};

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_vec(input string label, input logic rst, input logic [5:0] op,
                         input logic rdy, input logic [3:0] st, input logic [19:0] ctl);
    vec_t v;
    v.label = label;
    v.rst   = rst;
    v.op    = op;
    v.rdy   = rdy;
    v.st    = st;
    v.ctl   = ctl;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    bus.Op        = v.op;
    bus.mem_ready = v.rdy;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checks++;
    if (bus.state !== v.st) begin
      errors++;
      $display("[TB] FAIL %s row%0d state got %0d want %0d", v.label, idx, bus.state, v.st);
    end
    checks++;
    if (act_ctl !== v.ctl) begin
      errors++;
      $display("[TB] FAIL %s row%0d controls got %05h want %05h", v.label, idx, act_ctl, v.ctl);
    end
  endtask

  // Runs one instruction from FETCH with mem_ready high and counts cycles to instr_done.
  task automatic measure_latency(input string label, input logic [5:0] op, input int want);
    int  cycles;
    bit  done;
    cycles = 0;
    done   = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      reset         = 1'b0;
      bus.Op        = op;
      bus.mem_ready = 1'b1;
      #1;
      cycles++;
      if (bus.instr_done === 1'b1) done = 1'b1;
    end
    checks++;
    if (!done || cycles != want) begin
      errors++;
      $display("[TB] FAIL latency_%s got %0d cycles (done=%0b) want %0d", label, cycles, done, want);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.Op        = 6'b000000;
    bus.mem_ready = 1'b0;

    add_vec("reset",   1'b1, OP_R,    1'b1, 4'd0,  C_RST);
    add_vec("reset",   1'b1, OP_R,    1'b0, 4'd0,  C_RST);
    add_vec("rtype",   1'b0, OP_R,    1'b1, 4'd0,  C_FRDY);
    add_vec("rtype",   1'b0, OP_R,    1'b1, 4'd1,  C_DEC);
    add_vec("rtype",   1'b0, OP_R,    1'b1, 4'd6,  C_REX);
    add_vec("rtype",   1'b0, OP_R,    1'b1, 4'd7,  C_RWB);
    add_vec("lw",      1'b0, OP_LW,   1'b1, 4'd0,  C_FRDY);
    add_vec("lw",      1'b0, OP_LW,   1'b1, 4'd1,  C_DEC);
    add_vec("lw",      1'b0, OP_LW,   1'b1, 4'd2,  C_MADR);
    add_vec("lw",      1'b0, OP_LW,   1'b0, 4'd3,  C_MRD);
    add_vec("lw",      1'b0, OP_LW,   1'b0, 4'd3,  C_MRD);
    add_vec("lw",      1'b0, OP_LW,   1'b1, 4'd3,  C_MRD);
    add_vec("lw",      1'b0, OP_LW,   1'b1, 4'd4,  C_MWB);
    add_vec("sw",      1'b0, OP_SW,   1'b0, 4'd0,  C_FWAIT);
    add_vec("sw",      1'b0, OP_SW,   1'b1, 4'd0,  C_FRDY);
    add_vec("sw",      1'b0, OP_SW,   1'b1, 4'd1,  C_DEC);
    add_vec("sw",      1'b0, OP_SW,   1'b1, 4'd2,  C_MADR);
    add_vec("sw",      1'b0, OP_SW,   1'b0, 4'd5,  C_MWRW);
    add_vec("sw",      1'b0, OP_SW,   1'b1, 4'd5,  C_MWRD);
    add_vec("beq",     1'b0, OP_BEQ,  1'b1, 4'd0,  C_FRDY);
    add_vec("beq",     1'b0, OP_BEQ,  1'b1, 4'd1,  C_DEC);
    add_vec("beq",     1'b0, OP_BAD,  1'b1, 4'd8,  C_BEQ);
    add_vec("jump",    1'b0, OP_J,    1'b1, 4'd0,  C_FRDY);
    add_vec("jump",    1'b0, OP_J,    1'b1, 4'd1,  C_DEC);
    add_vec("jump",    1'b0, OP_LW,   1'b1, 4'd11, C_JMP);
    add_vec("addi",    1'b0, OP_ADDI, 1'b1, 4'd0,  C_FRDY);
    add_vec("addi",    1'b0, OP_ADDI, 1'b1, 4'd1,  C_DEC);
    add_vec("addi",    1'b0, OP_ORI,  1'b1, 4'd9,  C_ADDI);
    add_vec("addi",    1'b0, OP_ORI,  1'b1, 4'd10, C_IWB);
    add_vec("ori",     1'b0, OP_ORI,  1'b1, 4'd0,  C_FRDY);
    add_vec("ori",     1'b0, OP_ORI,  1'b1, 4'd1,  C_DEC);
    add_vec("ori",     1'b0, OP_ADDI, 1'b1, 4'd9,  C_ORI);
    add_vec("ori",     1'b0, OP_ADDI, 1'b1, 4'd10, C_IWB);
    add_vec("andi",    1'b0, OP_ANDI, 1'b1, 4'd0,  C_FRDY);
    add_vec("andi",    1'b0, OP_ANDI, 1'b1, 4'd1,  C_DEC);
    add_vec("andi",    1'b0, OP_R,    1'b1, 4'd9,  C_ANDI);
    add_vec("andi",    1'b0, OP_R,    1'b1, 4'd10, C_IWB);
    add_vec("xori",    1'b0, OP_XORI, 1'b1, 4'd0,  C_FRDY);
    add_vec("xori",    1'b0, OP_XORI, 1'b1, 4'd1,  C_DEC);
    add_vec("xori",    1'b0, OP_XORI, 1'b1, 4'd9,  C_XORI);
    add_vec("xori",    1'b0, OP_XORI, 1'b1, 4'd10, C_IWB);
    add_vec("illegal", 1'b0, OP_BAD,  1'b1, 4'd0,  C_FRDY);
    add_vec("illegal", 1'b0, OP_BAD,  1'b1, 4'd1,  C_DECILL);
    add_vec("illegal", 1'b0, OP_SW,   1'b1, 4'd0,  C_FRDY);
    add_vec("rst_mwr", 1'b0, OP_SW,   1'b1, 4'd1,  C_DEC);
    add_vec("rst_mwr", 1'b0, OP_SW,   1'b1, 4'd2,  C_MADR);
    add_vec("rst_mwr", 1'b0, OP_SW,   1'b0, 4'd5,  C_MWRW);
    add_vec("rst_mwr", 1'b1, OP_SW,   1'b0, 4'd5,  C_RST);
    add_vec("rst_mwr", 1'b0, OP_R,    1'b1, 4'd0,  C_FRDY);
    add_vec("illegal2",1'b0, OP_BAD2, 1'b1, 4'd1,  C_DECILL);
    add_vec("illegal2",1'b0, OP_BAD2, 1'b0, 4'd0,  C_FWAIT);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    measure_latency("rtype", OP_R,    4);
    measure_latency("lw",    OP_LW,   5);
    measure_latency("sw",    OP_SW,   4);
    measure_latency("beq",   OP_BEQ,  3);
    measure_latency("j",     OP_J,    3);
    measure_latency("ori",   OP_ORI,  4);
    measure_latency("addi",  OP_ADDI, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
